// File: rtl/autorepeat_pkg.sv
// Shared types and constants for the autorepeat button pulser.
package autorepeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } ar_state_t;

  // Divisor applied to REPEAT_CYCLES once the repeat rate accelerates.
  localparam int ACCEL_DIV = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous level and flags a 0->1 step.
// The prev register runs through reset so a level held across reset is not an edge.
module rise_detect (
  input  logic clk,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/autorepeat_pulser.sv
// Turns a debounced button level into one-cycle increment strobes with hold-to-repeat.
// Define AUTOREPEAT_ACCEL_EN to shorten the repeat period after ACCEL_AFTER repeats.
module autorepeat_pulser
  import autorepeat_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int ACCEL_AFTER   = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      debounced,
  output logic      pulse,
  output logic      repeating,
  output ar_state_t dbg_state
);

  localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SLOW_LAST = TW'(REPEAT_CYCLES - 1);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || ACCEL_AFTER < 1) begin : g_bad_params
    $error("autorepeat_pulser: HOLD_CYCLES and REPEAT_CYCLES must be >= 2, ACCEL_AFTER >= 1");
  end

  ar_state_t     r_state;
  ar_state_t     w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [TW-1:0] w_period_last;
  logic          r_pulse;
  logic          w_pulse_next;
  logic          r_repeating;
  logic          w_rise;

  rise_detect u_rise_detect (
    .clk     (clk),
    .i_level (debounced),
    .o_rise  (w_rise)
  );

`ifdef AUTOREPEAT_ACCEL_EN
  localparam int CW        = $clog2(ACCEL_AFTER + 1);
  localparam int FAST_RAW  = REPEAT_CYCLES / ACCEL_DIV;
  localparam int FAST      = (FAST_RAW < 2) ? 2 : FAST_RAW;
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST - 1);
  localparam logic [CW-1:0] COUNT_SAT = CW'(ACCEL_AFTER);

  logic [CW-1:0] r_count;
  logic          w_rep_hit;

  assign w_period_last = (r_count == COUNT_SAT) ? FAST_LAST : SLOW_LAST;
  assign w_rep_hit     = debounced && (r_state == REPEAT) && (r_timer == w_period_last);

  // Count of repeat pulses since the press; a release clears it.
  always_ff @(posedge clk) begin
    if (reset || !debounced) begin
      r_count <= '0;
    end else if (w_rep_hit && (r_count != COUNT_SAT)) begin
      r_count <= r_count + CW'(1);
    end
  end
`else
  assign w_period_last = SLOW_LAST;
`endif

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_pulse_next = 1'b0;
    if (!debounced) begin
      // Release beats a terminal count in the same cycle.
      w_state_next = IDLE;
      w_timer_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_next = HOLD;
            w_timer_next = '0;
            w_pulse_next = 1'b1;
          end
        end
        HOLD: begin
          if (r_timer == HOLD_LAST) begin
            w_state_next = REPEAT;
            w_timer_next = '0;
            w_pulse_next = 1'b1;
          end else begin
            w_timer_next = r_timer + TW'(1);
          end
        end
        REPEAT: begin
          if (r_timer == w_period_last) begin
            w_timer_next = '0;
            w_pulse_next = 1'b1;
          end else begin
            w_timer_next = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_pulse     <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_pulse     <= w_pulse_next;
      r_repeating <= (w_state_next == REPEAT);
    end
  end

  assign pulse     = r_pulse;
  assign repeating = r_repeating;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_autorepeat_pulser.sv
// Directed bench for autorepeat_pulser: per-cycle model compare plus literal pulse schedules.
// Honours AUTOREPEAT_ACCEL_EN the same way the design does.
module tb_autorepeat_pulser;
  import autorepeat_pkg::*;

  localparam int H    = 10;
  localparam int R    = 8;
  localparam int A    = 2;
  localparam int FAST = ((R / 4) < 2) ? 2 : (R / 4);

  logic      clk = 1'b0;
  logic      reset;
  logic      debounced;
  logic      pulse;
  logic      repeating;
  ar_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rep_cnt  = 0;
  bit check_en = 1'b0;
  bit last_pulse = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  autorepeat_pulser #(
    .HOLD_CYCLES   (H),
    .REPEAT_CYCLES (R),
    .ACCEL_AFTER   (A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .debounced (debounced),
    .pulse     (pulse),
    .repeating (repeating),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Offset k counts cycles since the press pulse; decide from the timing rules alone.
  function automatic bit is_offset(input int k);
    int j;
    if (k == 0) return 1'b1;
    if (k < H) return 1'b0;
    j = k - H;
`ifdef AUTOREPEAT_ACCEL_EN
    if (j <= A * R) return (j % R) == 0;
    return ((j - A * R) % FAST) == 0;
`else
    return (j % R) == 0;
`endif
  endfunction

  bit m_prev = 1'b0;
  bit m_active = 1'b0;
  int m_k = 0;
  bit exp_pulse = 1'b0;
  bit exp_rep = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_active = 1'b0;
    end else if (debounced && !m_prev) begin
      m_active = 1'b1;
      m_k = 0;
    end else if (m_active && debounced) begin
      m_k = m_k + 1;
    end else begin
      m_active = 1'b0;
    end
    m_prev    = debounced;
    exp_pulse = m_active && is_offset(m_k);
    exp_rep   = m_active && (m_k >= H);
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("pulse", 32'(pulse), 32'(exp_pulse));
      check("repeating", 32'(repeating), 32'(exp_rep));
      if (pulse) begin
        check("no_back_to_back", 32'(last_pulse), 32'd0);
        got_q.push_back(16'(cyc));
      end
      if (repeating) rep_cnt++;
      last_pulse = pulse;
    end
  end

  task automatic check_schedule(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < got_q.size(); i++) begin
        check({name, "_offset"}, 32'(got_q[i] - got_q[0]), 32'(exp_q[i]));
      end
    end
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    rep_cnt = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic d, input int n);
    debounced = d;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    debounced = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_repeating", 32'(repeating), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    drive(1'b0, 3);

    // 1: short press, single pulse
    start_test();
    drive(1'b1, 3);
    drive(1'b0, 15);
    exp_q = '{16'd0};
    check_schedule("t1");
    check("t1_repeating_cycles", 32'(rep_cnt), 32'd0);

    // 2/3: long hold, repeat schedule depends on acceleration
    start_test();
    drive(1'b1, 40);
    drive(1'b0, 15);
`ifdef AUTOREPEAT_ACCEL_EN
    exp_q = '{16'd0, 16'd10, 16'd18, 16'd26, 16'd28, 16'd30, 16'd32, 16'd34, 16'd36, 16'd38};
`else
    exp_q = '{16'd0, 16'd10, 16'd18, 16'd26, 16'd34};
`endif
    check_schedule("t2");
    check("t2_repeating_cycles", 32'(rep_cnt), 32'd30);

    // 4: release exactly when the first repeat is due, then re-press
    start_test();
    drive(1'b1, 10);
    drive(1'b0, 1);
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    drive(1'b1, 5);
    drive(1'b0, 15);
    exp_q = '{16'd0, 16'd11};
    check_schedule("t4");
    check("t4_repeating_cycles", 32'(rep_cnt), 32'd0);

    // 5: reset while held; no pulses until a fresh press
    start_test();
    drive(1'b1, 15);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t5_repeating_after_reset", 32'(repeating), 32'd0);
    drive(1'b1, 14);
    drive(1'b0, 3);
    exp_q = '{16'd0, 16'd10};
    check_schedule("t5a");
    start_test();
    drive(1'b1, 3);
    drive(1'b0, 15);
    exp_q = '{16'd0};
    check_schedule("t5b");

    // 6: button held through reset gives no pulse; a fresh press gives one
    start_test();
    debounced = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 10);
    check("t6_no_pulse_after_reset", 32'(got_q.size()), 32'd0);
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 15);
    exp_q = '{16'd0};
    check_schedule("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
